router_fsm: RTL and testbench
=============================

// Module: router_fsm
// PURPOSE
//   Packet-reception controller for the 1x3 router. Sequences header decode, payload load,
//   parity load and FIFO-full stalls. Drives the register block and the synchronizer
//   (detect_addr, wr_en_reg) so writes reach the destination FIFO selected by header din[1:0].
//   Sits between the input port and the register/synchronizer/FIFO datapath.
// PARAMETERS
//   ADDR_MAX   2   highest valid destination address; din > ADDR_MAX is ignored in DECODE
// PORTS
//   clk            in   1  rising-edge clock
//   rst            in   1  asynchronous, active-high reset
//   pkt_valid      in   1  packet valid from source; high during header and payload, low on parity byte
//   din            in   2  destination address field of the header byte
//   parity_done    in   1  register block has captured the parity byte
//   low_pkt_valid  in   1  register block saw pkt_valid fall while a byte was held during full
//   fifo_full      in   1  full flag of the selected FIFO, from the synchronizer
//   fifo_empty_0/1/2 in 1  empty flags of FIFOs 0..2
//   soft_reset_0/1/2 in 1  timeout soft resets from the synchronizer, one per FIFO
//   detect_addr    out  1  header cycle: synchronizer latches din
//   lfd_state      out  1  loading header (first data) byte
//   ld_state       out  1  loading payload byte
//   laf_state      out  1  loading the byte held during FIFO full
//   full_state     out  1  stalled on FIFO full
//   rst_int_reg    out  1  clear the internal parity registers of the register block
//   wr_en_reg      out  1  FIFO write request to the synchronizer
//   busy           out  1  source must hold its current byte
// BEHAVIOUR
//   - Moore FSM: one state register, 3 bits. Outputs are decoded combinationally from state only.
//   - addr_q[1:0] captures din in DECODE when pkt_valid is high and din <= ADDR_MAX.
//     sel_empty = fifo_empty_[addr_q]. sel_sr = soft_reset_[addr_q].
//   - Reset (async, rst=1): state=DECODE, addr_q=0.
//     Outputs during reset: detect_addr=1; all other outputs 0.
//   - States, output sets, and next-state rules:
//     DECODE : detect_addr=1
//       - pkt_valid && din<=ADDR_MAX && fifo_empty_[din]  -> LFD
//       - pkt_valid && din<=ADDR_MAX && !fifo_empty_[din] -> WAIT_EMPTY
//       - otherwise (including din==3)                    -> stay
//     LFD : lfd_state=1, busy=1, wr_en_reg=1
//       - always -> LOAD_DATA (header written one cycle after DECODE)
//     LOAD_DATA : ld_state=1, wr_en_reg=1, busy=0
//       - fifo_full  -> FULL
//       - !pkt_valid -> LOAD_PARITY
//       - otherwise  -> stay
//       - fifo_full takes priority over !pkt_valid.
//     LOAD_PARITY : busy=1, wr_en_reg=1
//       - always -> CHECK_PARITY
//     CHECK_PARITY : rst_int_reg=1, busy=1
//       - fifo_full -> FULL
//       - otherwise -> DECODE
//     FULL : full_state=1, busy=1, wr_en_reg=0
//       - !fifo_full -> LAF
//       - otherwise  -> stay
//     LAF : laf_state=1, busy=1, wr_en_reg=1
//       - parity_done   -> DECODE
//       - low_pkt_valid -> LOAD_PARITY
//       - otherwise     -> LOAD_DATA
//     WAIT_EMPTY : busy=1, wr_en_reg=0
//       - sel_empty -> LFD
//       - otherwise -> stay
//   - Soft reset: in any state except DECODE, sel_sr=1 forces next state = DECODE.
//     It has priority over every other transition.
//   - Unused state encodings go to DECODE on the next clock.
//   - Reset asserted mid-packet: immediate return to DECODE; no write issued in that cycle.
// TESTING
//   1. Reset, pkt_valid=1, din=1, fifo_empty_1=1 -> DECODE,LFD,LOAD_DATA; detect_addr=1 only in cycle 0, busy=1 in LFD.
//   2. 4-byte payload, then pkt_valid=0 -> LOAD_PARITY then CHECK_PARITY (rst_int_reg=1 one cycle), then DECODE.
//   3. fifo_full=1 in LOAD_DATA for 5 cycles -> FULL for 5 cycles (wr_en_reg=0, busy=1), then LAF, then LOAD_DATA.
//   4. din=2, fifo_empty_2=0 for 10 cycles -> WAIT_EMPTY for 10 cycles with busy=1, then LFD on the cycle after empty rises.
//   5. soft_reset_0=1 while in LOAD_DATA to addr 0 -> DECODE next cycle; soft_reset_1 at the same time has no effect.
//   6. din=3 with pkt_valid=1 -> stays in DECODE; rst asserted in LAF -> DECODE asynchronously, detect_addr=1.

Source files
------------

// File: rtl/router_fsm.sv
// Packet-reception controller for the 1x3 router: sequences header decode,
// payload/parity load and FIFO-full stalls for the register block and synchronizer.
module router_fsm #(
  parameter int ADDR_MAX = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pkt_valid,
  input  logic [1:0] din,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  input  logic       fifo_full,
  input  logic       fifo_empty_0,
  input  logic       fifo_empty_1,
  input  logic       fifo_empty_2,
  input  logic       soft_reset_0,
  input  logic       soft_reset_1,
  input  logic       soft_reset_2,
  output logic       detect_addr,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       rst_int_reg,
  output logic       wr_en_reg,
  output logic       busy
);

  localparam logic [1:0] AMAX = 2'(ADDR_MAX);

  typedef enum logic [2:0] {
    DECODE       = 3'd0,
    LFD          = 3'd1,
    LOAD_DATA    = 3'd2,
    LOAD_PARITY  = 3'd3,
    CHECK_PARITY = 3'd4,
    FULL         = 3'd5,
    LAF          = 3'd6,
    WAIT_EMPTY   = 3'd7
  } state_t;

  state_t     state, state_n;
  logic [1:0] addr_q;
  logic [3:0] empty_v, sr_v;
  logic       addr_ok, sel_empty, sel_sr;

  // Address 3 has no FIFO; its slot reads as not-empty / no soft reset.
  assign empty_v   = {1'b0, fifo_empty_2, fifo_empty_1, fifo_empty_0};
  assign sr_v      = {1'b0, soft_reset_2, soft_reset_1, soft_reset_0};
  assign addr_ok   = pkt_valid && (din <= AMAX);
  assign sel_empty = empty_v[addr_q];
  assign sel_sr    = sr_v[addr_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= DECODE;
      addr_q <= 2'd0;
    end else begin
      state <= state_n;
      if (state == DECODE && addr_ok) addr_q <= din;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      DECODE:       if (addr_ok) state_n = empty_v[din] ? LFD : WAIT_EMPTY;
      LFD:          state_n = LOAD_DATA;
      LOAD_DATA: begin
        if (fifo_full)       state_n = FULL;
        else if (!pkt_valid) state_n = LOAD_PARITY;
      end
      LOAD_PARITY:  state_n = CHECK_PARITY;
      CHECK_PARITY: state_n = fifo_full ? FULL : DECODE;
      FULL:         if (!fifo_full) state_n = LAF;
      LAF: begin
        if (parity_done)        state_n = DECODE;
        else if (low_pkt_valid) state_n = LOAD_PARITY;
        else                    state_n = LOAD_DATA;
      end
      WAIT_EMPTY:   if (sel_empty) state_n = LFD;
      default:      state_n = DECODE;
    endcase
    // Timeout soft reset of the selected FIFO aborts the packet from any state.
    if (state != DECODE && sel_sr) state_n = DECODE;
  end

  always_comb begin
    detect_addr = 1'b0;
    lfd_state   = 1'b0;
    ld_state    = 1'b0;
    laf_state   = 1'b0;
    full_state  = 1'b0;
    rst_int_reg = 1'b0;
    wr_en_reg   = 1'b0;
    busy        = 1'b0;
    case (state)
      DECODE:       detect_addr = 1'b1;
      LFD:          begin lfd_state = 1'b1; busy = 1'b1; wr_en_reg = 1'b1; end
      LOAD_DATA:    begin ld_state = 1'b1; wr_en_reg = 1'b1; end
      LOAD_PARITY:  begin busy = 1'b1; wr_en_reg = 1'b1; end
      CHECK_PARITY: begin rst_int_reg = 1'b1; busy = 1'b1; end
      FULL:         begin full_state = 1'b1; busy = 1'b1; end
      LAF:          begin laf_state = 1'b1; busy = 1'b1; wr_en_reg = 1'b1; end
      WAIT_EMPTY:   busy = 1'b1;
      default:      detect_addr = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_router_fsm.sv
// Bench for router_fsm: table of per-cycle stimulus with expected state outputs,
// scoreboarded through a queue, plus a hand-written async-reset-in-LAF sequence.
module tb_router_fsm;

  logic       clk = 1'b0, rst = 1'b1;
  logic       pkt_valid = 1'b0, parity_done = 1'b0, low_pkt_valid = 1'b0, fifo_full = 1'b0;
  logic [1:0] din = 2'd0;
  logic [2:0] emp = 3'b000, sr = 3'b000;
  logic       detect_addr, lfd_state, ld_state, laf_state, full_state, rst_int_reg, wr_en_reg, busy;

  // {detect_addr, lfd, ld, laf, full, rst_int_reg, wr_en_reg, busy}
  localparam logic [7:0] O_DEC  = 8'b1000_0000;
  localparam logic [7:0] O_LFD  = 8'b0100_0011;
  localparam logic [7:0] O_LD   = 8'b0010_0010;
  localparam logic [7:0] O_LP   = 8'b0000_0011;
  localparam logic [7:0] O_CP   = 8'b0000_0101;
  localparam logic [7:0] O_FULL = 8'b0000_1001;
  localparam logic [7:0] O_LAF  = 8'b0001_0011;
  localparam logic [7:0] O_WE   = 8'b0000_0001;

  typedef struct {
    logic       pv;
    logic [1:0] din;
    logic       pd;
    logic       lpv;
    logic       full;
    logic [2:0] emp;
    logic [2:0] sr;
    logic [7:0] exp;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] exp_q[$];
  int         tests = 0, fails = 0;

  router_fsm #(.ADDR_MAX(2)) dut (
    .clk(clk), .rst(rst), .pkt_valid(pkt_valid), .din(din),
    .parity_done(parity_done), .low_pkt_valid(low_pkt_valid), .fifo_full(fifo_full),
    .fifo_empty_0(emp[0]), .fifo_empty_1(emp[1]), .fifo_empty_2(emp[2]),
    .soft_reset_0(sr[0]), .soft_reset_1(sr[1]), .soft_reset_2(sr[2]),
    .detect_addr(detect_addr), .lfd_state(lfd_state), .ld_state(ld_state),
    .laf_state(laf_state), .full_state(full_state), .rst_int_reg(rst_int_reg),
    .wr_en_reg(wr_en_reg), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] outs();
    return {detect_addr, lfd_state, ld_state, laf_state, full_state, rst_int_reg, wr_en_reg, busy};
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic add(input logic pv, input logic [1:0] d, input logic pd, input logic lpv,
                     input logic full, input logic [2:0] e, input logic [2:0] s, input logic [7:0] exp);
    vec_t v;
    v.pv = pv; v.din = d; v.pd = pd; v.lpv = lpv; v.full = full; v.emp = e; v.sr = s; v.exp = exp;
    vecs.push_back(v);
  endtask

  // Drive one cycle of inputs, queue the expected outputs, compare after the edge.
  task automatic step(input vec_t v, input int idx);
    logic [7:0] e;
    pkt_valid = v.pv; din = v.din; parity_done = v.pd; low_pkt_valid = v.lpv;
    fifo_full = v.full; emp = v.emp; sr = v.sr;
    exp_q.push_back(v.exp);
    @(posedge clk); #1;
    if (exp_q.size() == 0) begin
      check($sformatf("vec%0d_scoreboard_empty", idx), 8'h00, 8'hFF);
    end else begin
      e = exp_q.pop_front();
      check($sformatf("vec%0d", idx), outs(), e);
    end
  endtask

  initial begin
    // pv din pd lpv full emp sr expected-after-edge
    // Header to addr 1, 4-byte payload, parity, check.
    add(1, 1, 0, 0, 0, 3'b111, 3'b000, O_LFD);
    add(1, 0, 0, 0, 0, 3'b111, 3'b000, O_LD);
    add(1, 0, 0, 0, 0, 3'b111, 3'b000, O_LD);
    add(1, 0, 0, 0, 0, 3'b111, 3'b000, O_LD);
    add(1, 0, 0, 0, 0, 3'b111, 3'b000, O_LD);
    add(0, 0, 0, 0, 0, 3'b111, 3'b000, O_LP);
    add(0, 0, 0, 0, 0, 3'b111, 3'b000, O_CP);
    add(0, 0, 0, 0, 0, 3'b111, 3'b000, O_DEC);
    // FIFO full for 5 cycles in LOAD_DATA, then LAF -> LOAD_DATA.
    add(1, 0, 0, 0, 0, 3'b111, 3'b000, O_LFD);
    add(1, 0, 0, 0, 0, 3'b111, 3'b000, O_LD);
    for (int i = 0; i < 5; i++) add(1, 0, 0, 0, 1, 3'b111, 3'b000, O_FULL);
    add(1, 0, 0, 0, 0, 3'b111, 3'b000, O_LAF);
    add(1, 0, 0, 0, 0, 3'b111, 3'b000, O_LD);
    // LAF with low_pkt_valid -> LOAD_PARITY; full in CHECK_PARITY; LAF with parity_done -> DECODE.
    add(1, 0, 0, 0, 1, 3'b111, 3'b000, O_FULL);
    add(1, 0, 0, 0, 0, 3'b111, 3'b000, O_LAF);
    add(0, 0, 0, 1, 0, 3'b111, 3'b000, O_LP);
    add(0, 0, 0, 0, 0, 3'b111, 3'b000, O_CP);
    add(0, 0, 0, 0, 1, 3'b111, 3'b000, O_FULL);
    add(0, 0, 0, 0, 0, 3'b111, 3'b000, O_LAF);
    add(0, 0, 1, 1, 0, 3'b111, 3'b000, O_DEC);
    // Addr 2 not empty for 10 cycles -> WAIT_EMPTY, then LFD.
    for (int i = 0; i < 10; i++) add(1, 2, 0, 0, 0, 3'b011, 3'b000, O_WE);
    add(1, 2, 0, 0, 0, 3'b111, 3'b000, O_LFD);
    add(1, 2, 0, 0, 0, 3'b111, 3'b000, O_LD);
    add(0, 2, 0, 0, 0, 3'b111, 3'b000, O_LP);
    add(0, 2, 0, 0, 0, 3'b111, 3'b000, O_CP);
    add(0, 2, 0, 0, 0, 3'b111, 3'b000, O_DEC);
    // din=3 is ignored; pkt_valid low is ignored.
    add(1, 3, 0, 0, 0, 3'b111, 3'b000, O_DEC);
    add(0, 1, 0, 0, 0, 3'b111, 3'b000, O_DEC);
    // Soft reset: only the selected FIFO's flag counts.
    add(1, 0, 0, 0, 0, 3'b111, 3'b000, O_LFD);
    add(1, 0, 0, 0, 0, 3'b111, 3'b000, O_LD);
    add(1, 0, 0, 0, 0, 3'b111, 3'b010, O_LD);
    add(1, 0, 0, 0, 0, 3'b111, 3'b001, O_DEC);
    // Soft reset beats FULL's stay.
    add(1, 0, 0, 0, 0, 3'b111, 3'b000, O_LFD);
    add(1, 0, 0, 0, 0, 3'b111, 3'b000, O_LD);
    add(1, 0, 0, 0, 1, 3'b111, 3'b000, O_FULL);
    add(1, 0, 0, 0, 1, 3'b111, 3'b001, O_DEC);
    // Soft reset ignored in DECODE; then addr 1 selected.
    add(1, 1, 0, 0, 0, 3'b111, 3'b111, O_LFD);
    add(1, 1, 0, 0, 0, 3'b111, 3'b000, O_LD);
    add(1, 1, 0, 0, 0, 3'b111, 3'b101, O_LD);
    add(1, 1, 0, 0, 0, 3'b111, 3'b010, O_DEC);

    // Reset state.
    #12;
    check("reset_outputs", outs(), O_DEC);
    @(posedge clk); #1;
    check("reset_held_outputs", outs(), O_DEC);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) step(vecs[i], i);

    // Async reset while in LAF: outputs return to DECODE without a clock.
    begin
      vec_t v;
      v.pv = 1; v.din = 0; v.pd = 0; v.lpv = 0; v.full = 0; v.emp = 3'b111; v.sr = 3'b000;
      v.exp = O_LFD;  step(v, 100);
      v.exp = O_LD;   step(v, 101);
      v.full = 1; v.exp = O_FULL; step(v, 102);
      v.full = 0; v.exp = O_LAF;  step(v, 103);
      #2 rst = 1'b1;
      #1 check("async_rst_in_laf", outs(), O_DEC);
      @(posedge clk); #1;
      check("rst_held_decode", outs(), O_DEC);
      rst = 1'b0;
      v.din = 1; v.exp = O_LFD; step(v, 104);
      v.exp = O_LD;  step(v, 105);
    end

    check("scoreboard_drained", 8'(exp_q.size()), 8'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
